// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port req/ack arbiter in front of a single-port data memory
//
// Purpose: shares one data memory between the CPU load/store path and a
// debug/loader port. Every access is sequenced through IDLE -> WRITE or
// IDLE -> READ -> RESP. The CPU wins ties, but after STARVE_MAX consecutive
// CPU wins over a waiting debug request, the debug port is granted.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata       one-cycle completion pulse, read data (rdata_q)
//   dbg_req/we/addr/wdata    debug request, held stable until dbg_ack
//   dbg_ack, dbg_rdata       one-cycle completion pulse, read data (rdata_q)
//   mem_addr, mem_wdata      latched request address / write data
//   mem_rd, mem_wr           memory strobes, high only in READ / WRITE
//   mem_rdata                memory read data, valid RD_LAT cycles after mem_rd rises
//   busy                     high whenever the FSM is not IDLE
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  // RD_LAT is 1..4, so the in-read cycle index fits in two bits.
  localparam int LAT_W = 2;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              gnt_dbg_q, gnt_dbg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick_dbg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      starve_q  <= '0;
      gnt_dbg_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      starve_q  <= starve_d;
      gnt_dbg_q <= gnt_dbg_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Debug wins when it is alone, or when it has been passed over STARVE_MAX times.
  assign pick_dbg = dbg_req && (!cpu_req || (starve_q == CNT_MAX));

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    starve_d  = starve_q;
    gnt_dbg_d = gnt_dbg_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          gnt_dbg_d = pick_dbg;
          lat_cnt_d = '0;
          if (pick_dbg) begin
            starve_d = '0;
            addr_d   = dbg_addr;
            wdata_d  = dbg_wdata;
            state_d  = dbg_we ? WRITE : READ;
          end else begin
            // Reaching CNT_MAX forces the next contested grant to debug,
            // so this increment never passes the saturation value.
            if (dbg_req) starve_d = starve_q + CNT_W'(1);
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            state_d = cpu_we ? WRITE : READ;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks decode the registered state directly so that an
  // asynchronous reset removes them without waiting for a clock.
  assign mem_rd    = (state_q == READ);
  assign mem_wr    = (state_q == WRITE);
  assign cpu_ack   = ((state_q == WRITE) || (state_q == RESP)) && !gnt_dbg_q;
  assign dbg_ack   = ((state_q == WRITE) || (state_q == RESP)) &&  gnt_dbg_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter at RD_LAT=1 and RD_LAT=3
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;

  // u1: RD_LAT=1, u3: RD_LAT=3; both see identical requester stimulus.
  logic        cpu_ack1, dbg_ack1, mem_rd1, mem_wr1, busy1;
  logic [15:0] cpu_rdata1, dbg_rdata1, mem_wdata1, mem_rdata1;
  logic [7:0]  mem_addr1;
  logic        cpu_ack3, dbg_ack3, mem_rd3, mem_wr3, busy3;
  logic [15:0] cpu_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
  logic [7:0]  mem_addr3;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1));

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_wr(mem_wr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

  // Memory models: data is only presented in the RD_LAT-th cycle of mem_rd,
  // otherwise a poison value, so a wrong capture cycle shows up as 0xDEAD.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [2:0]  rc1, rc3;

  always @(posedge clk) begin
    if (mem_wr1) mem1[mem_addr1] <= mem_wdata1;
    if (mem_wr3) mem3[mem_addr3] <= mem_wdata3;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc1 <= '0;
      rc3 <= '0;
    end else begin
      rc1 <= mem_rd1 ? rc1 + 3'd1 : 3'd0;
      rc3 <= mem_rd3 ? rc3 + 3'd1 : 3'd0;
    end
  end

  assign mem_rdata1 = (mem_rd1 && rc1 == 3'd0) ? mem1[mem_addr1] : 16'hDEAD;
  assign mem_rdata3 = (mem_rd3 && rc3 == 3'd2) ? mem3[mem_addr3] : 16'hDEAD;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with random inputs, all outputs zero
    #1;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 8'($urandom); cpu_wdata = 16'($urandom);
      dbg_req = 1'($urandom); dbg_we = 1'($urandom);
      dbg_addr = 8'($urandom); dbg_wdata = 16'($urandom);
      step();
      chk("rst_ctl1", 32'({cpu_ack1, dbg_ack1, mem_rd1, mem_wr1, busy1}), 32'd0);
      chk("rst_ctl3", 32'({cpu_ack3, dbg_ack3, mem_rd3, mem_wr3, busy3}), 32'd0);
      chk("rst_dat1", 32'(cpu_rdata1 | dbg_rdata1 | mem_wdata1 | 16'(mem_addr1)), 32'd0);
    end
    cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
    rst = 1'b1;
    step(); step();
    chk("idle_busy", 32'({busy1, busy3, mem_rd1, mem_wr1}), 32'd0);

    // 2: CPU write 0x12 <= 0xBEEF, then read back
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h12; cpu_wdata = 16'hBEEF;
    step();
    chk("wr_memwr", 32'(mem_wr1), 32'd1);
    chk("wr_ack", 32'(cpu_ack1), 32'd1);
    chk("wr_dbgack", 32'(dbg_ack1), 32'd0);
    chk("wr_addr", 32'(mem_addr1), 32'h12);
    chk("wr_wdata", 32'(mem_wdata1), 32'hBEEF);
    cpu_req = 0;
    step();
    chk("wr_done", 32'({mem_wr1, cpu_ack1, busy1}), 32'd0);
    cpu_req = 1; cpu_we = 0;
    step();
    chk("rd1_memrd", 32'(mem_rd1), 32'd1);
    chk("rd1_noack", 32'(cpu_ack1), 32'd0);
    step();
    chk("rd1_ack", 32'(cpu_ack1), 32'd1);
    chk("rd1_data", 32'(cpu_rdata1), 32'hBEEF);
    chk("rd1_dbgdata", 32'(dbg_rdata1), 32'hBEEF);
    cpu_req = 0;
    for (int i = 0; i < 6; i++) step();

    // 3: both requesting writes continuously: 4 CPU grants then 1 debug grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 16'hC0DE;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h30; dbg_wdata = 16'hD0D0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("arb_cpu%0d", i), 32'(cpu_ack1), (i % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("arb_dbg%0d", i), 32'(dbg_ack1), (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("arb_addr%0d", i), 32'(mem_addr1), (i % 5 == 4) ? 32'h30 : 32'h20);
      step();
      chk($sformatf("arb_idle%0d", i), 32'(busy1), 32'd0);
    end
    cpu_req = 0; dbg_req = 0;
    for (int i = 0; i < 6; i++) step();

    // 6: CPU holds req through ack for three writes
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b2b_ack%0d", i), 32'(cpu_ack1), 32'd1);
      chk($sformatf("b2b_addr%0d", i), 32'(mem_addr1), 32'(i + 1));
      if (i == 2) cpu_req = 0;
      cpu_addr = 8'(i + 2); cpu_wdata = 16'(16'h0101 * (i + 2));
      step();
      chk($sformatf("b2b_gap%0d", i), 32'({cpu_ack1, busy1}), 32'd0);
    end
    for (int i = 0; i < 4; i++) step();

    // preload 0x40 <= 0x1234 through the debug (loader) port
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 16'h1234;
    step();
    chk("ld_ack3", 32'(dbg_ack3), 32'd1);
    dbg_req = 0;
    for (int i = 0; i < 4; i++) step();

    // 4: RD_LAT=3 debug read of 0x40
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h40;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rd3_memrd%0d", k), 32'(mem_rd3), (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("rd3_dbgack%0d", k), 32'(dbg_ack3), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("rd3_cpuack%0d", k), 32'(cpu_ack3), 32'd0);
    end
    chk("rd3_data", 32'(dbg_rdata3), 32'h1234);
    dbg_req = 0;
    for (int i = 0; i < 6; i++) step();
    chk("rd3_hold", 32'(dbg_rdata3), 32'h1234);

    // 5: reset in the 2nd cycle of an RD_LAT=3 read
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
    step(); step();
    chk("rr_memrd_pre", 32'(mem_rd3), 32'd1);
    rst = 1'b0;
    #1;
    chk("rr_memrd", 32'(mem_rd3), 32'd0);
    chk("rr_busy", 32'(busy3), 32'd0);
    chk("rr_rdata", 32'(cpu_rdata3), 32'd0);
    cpu_req = 0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_noack", 32'({cpu_ack3, dbg_ack3, busy3}), 32'd0);
    end
    cpu_req = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rr2_ack%0d", k), 32'(cpu_ack3), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("rr2_data", 32'(cpu_rdata3), 32'hBEEF);
    cpu_req = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
